// File: rtl/neuron_train_ctrl.sv
// rtl/neuron_train_ctrl.sv - FP/BP phase sequencer for one sigmoid output neuron
// Optional misclassification counter: NEURON_TRAIN_CTRL_ACC_CNT_EN
module neuron_train_ctrl #(
   parameter int N         = 30,
   parameter int BITS      = 32,
   parameter int SW        = 16,
   parameter int FP_CYCLES = N / 2 + 4,
   parameter int BP_CYCLES = N + 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            train,
   input  logic [SW-1:0]   num_samples,
   input  logic            abort,
   input  logic [BITS-1:0] yhat,
   input  logic [BITS-1:0] y_true,
   output logic            fp,
   output logic            bp,
   output logic [SW-1:0]   sample_idx,
   output logic            y_latch,
   output logic            w_we,
   output logic            busy,
   output logic            done,
   output logic [SW-1:0]   err_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_FSETUP, S_FWD, S_BSETUP, S_BWD, S_WB, S_NEXT, S_DONE
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [7:0]    r_cnt;
   logic [7:0]    w_cnt_nxt;
   logic [SW-1:0] r_idx;
   logic [SW-1:0] w_idx_nxt;
   logic [SW-1:0] r_num;
   logic          r_train;
   logic          r_fp;
   logic          r_bp;
   logic          r_y_latch;
   logic          r_w_we;
   logic          r_busy;
   logic          r_done;
   logic          w_accept;
   logic          w_last;

   assign w_accept = (r_state == S_IDLE) && start && !abort;
   assign w_last   = (r_idx == (r_num - SW'(1)));

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      if (r_state != S_IDLE && abort) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  w_idx_nxt   = '0;
                  w_state_nxt = (num_samples == '0) ? S_DONE : S_FSETUP;
               end
            end
            S_FSETUP: begin
               w_state_nxt = S_FWD;
               w_cnt_nxt   = 8'(FP_CYCLES - 1);
            end
            S_FWD: begin
               if (r_cnt == 8'd0) w_state_nxt = r_train ? S_BSETUP : S_NEXT;
               else               w_cnt_nxt   = r_cnt - 8'd1;
            end
            S_BSETUP: begin
               w_state_nxt = S_BWD;
               w_cnt_nxt   = 8'(BP_CYCLES - 1);
            end
            S_BWD: begin
               if (r_cnt == 8'd0) w_state_nxt = S_WB;
               else               w_cnt_nxt   = r_cnt - 8'd1;
            end
            S_WB, S_NEXT: begin
               if (w_last) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_idx_nxt   = r_idx + SW'(1);
                  w_state_nxt = S_FSETUP;
               end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_num     <= '0;
         r_train   <= 1'b0;
         r_fp      <= 1'b0;
         r_bp      <= 1'b0;
         r_y_latch <= 1'b0;
         r_w_we    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_idx     <= w_idx_nxt;
         if (w_accept) begin
            r_train <= train;
            r_num   <= num_samples;
         end
         r_fp      <= (w_state_nxt == S_FWD) || (w_state_nxt == S_BSETUP);
         r_bp      <= (w_state_nxt == S_BSETUP) || (w_state_nxt == S_BWD);
         r_y_latch <= (w_state_nxt == S_BSETUP) || (w_state_nxt == S_NEXT);
         r_w_we    <= (w_state_nxt == S_WB);
         r_busy    <= (w_state_nxt != S_IDLE);
         r_done    <= (w_state_nxt == S_DONE);
      end
   end

   assign fp         = r_fp;
   assign bp         = r_bp;
   assign sample_idx = r_idx;
   assign y_latch    = r_y_latch;
   assign w_we       = r_w_we;
   assign busy       = r_busy;
   assign done       = r_done;

`ifdef NEURON_TRAIN_CTRL_ACC_CNT_EN
   logic [SW-1:0] r_err_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_cnt <= '0;
      end else if (w_accept) begin
         r_err_cnt <= '0;
      end else if (r_y_latch && (yhat != y_true) && (r_err_cnt != '1)) begin
         r_err_cnt <= r_err_cnt + SW'(1);
      end
   end

   assign err_cnt = r_err_cnt;
`else
   logic w_unused_labels;

   assign w_unused_labels = ^{yhat, y_true};
   assign err_cnt         = '0;
`endif

endmodule

// File: tb/tb_neuron_train_ctrl.sv
// tb/tb_neuron_train_ctrl.sv - scoreboard bench for neuron_train_ctrl
module tb_neuron_train_ctrl;

   typedef struct packed {
      logic        busy;
      logic        fp;
      logic        bp;
      logic        yl;
      logic        we;
      logic        dn;
      logic [15:0] idx;
      logic [15:0] err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        train = 1'b0;
   logic [15:0] num_samples = '0;
   logic        abort = 1'b0;
   logic [31:0] yhat = '0;
   logic [31:0] y_true = '0;
   logic        fp, bp, y_latch, w_we, busy, done;
   logic [15:0] sample_idx, err_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   vec_t        exp_q[$];
   vec_t        pv[$];
   logic [31:0] m_yh[0:7];
   logic [31:0] m_yt[0:7];
   int          m_idx = 0;
   int          m_err = 0;

   neuron_train_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .train(train),
      .num_samples(num_samples), .abort(abort), .yhat(yhat), .y_true(y_true),
      .fp(fp), .bp(bp), .sample_idx(sample_idx), .y_latch(y_latch),
      .w_we(w_we), .busy(busy), .done(done), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input bit b, input bit f, input bit p, input bit l,
                               input bit w, input bit d, input int idx, input int err);
      vec_t v;
      v.busy = b; v.fp = f; v.bp = p; v.yl = l; v.we = w; v.dn = d;
      v.idx = 16'(idx); v.err = 16'(err);
      return v;
   endfunction

   // Reference: the pass as a list of per-cycle phases derived from the phase lengths.
   task automatic build(input bit tr, input int n);
      int cur;
      cur = 0;
      pv.delete();
      for (int k = 0; k < n; k++) begin
         pv.push_back(mk(1, 0, 0, 0, 0, 0, k, cur));
         for (int c = 0; c < 19; c++) pv.push_back(mk(1, 1, 0, 0, 0, 0, k, cur));
         if (tr) begin
            pv.push_back(mk(1, 1, 1, 1, 0, 0, k, cur));
`ifdef NEURON_TRAIN_CTRL_ACC_CNT_EN
            if (m_yh[k] != m_yt[k]) cur++;
`endif
            for (int c = 0; c < 34; c++) pv.push_back(mk(1, 0, 1, 0, 0, 0, k, cur));
            pv.push_back(mk(1, 0, 0, 0, 1, 0, k, cur));
         end else begin
            pv.push_back(mk(1, 0, 0, 1, 0, 0, k, cur));
`ifdef NEURON_TRAIN_CTRL_ACC_CNT_EN
            if (m_yh[k] != m_yt[k]) cur++;
`endif
         end
      end
      pv.push_back(mk(1, 0, 0, 0, 0, 1, (n == 0) ? 0 : n - 1, cur));
   endtask

   task automatic step(input vec_t v, input bit st, input bit ab, input int di);
      start  = st;
      abort  = ab;
      yhat   = m_yh[di];
      y_true = m_yt[di];
      exp_q.push_back(v);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int cyc, input bit st, input bit ab);
      for (int c = 0; c < cyc; c++) step(mk(0, 0, 0, 0, 0, 0, m_idx, m_err), st, ab, m_idx);
      start = 1'b0;
      abort = 1'b0;
   endtask

   // abort_at: -1 none, -2 random; cut: number of pass cycles to run before returning.
   task automatic run_pass(input bit tr, input int n, input int abort_at,
                           input int busy_start_at, input int cut);
      int ab_i;
      int last;
      build(tr, n);
      ab_i = abort_at;
      if (ab_i == -2) begin
         ab_i = $urandom_range(0, pv.size() - 1);
         if (pv[ab_i].yl || pv[ab_i].dn) ab_i = -1;
      end
      train       = tr;
      num_samples = 16'(n);
      step(mk(0, 0, 0, 0, 0, 0, m_idx, m_err), 1'b1, 1'b0, m_idx);
      train       = ~tr;
      num_samples = 16'($urandom_range(0, 7));
      last = 0;
      for (int i = 0; i < pv.size() && i < cut; i++) begin
         last = i;
         step(pv[i], (i == busy_start_at), (i == ab_i), int'(pv[i].idx));
         if (i == ab_i) break;
      end
      start  = 1'b0;
      abort  = 1'b0;
      m_idx  = int'(pv[last].idx);
      m_err  = int'(pv[last].err);
   endtask

   always @(negedge clk) begin
      vec_t e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = mk(busy, fp, bp, y_latch, w_we, done, int'(sample_idx), int'(err_cnt));
         n_tests++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL cycle_vec t=%0t act busy/fp/bp/yl/we/dn=%b%b%b%b%b%b idx=%0d err=%0d exp=%b%b%b%b%b%b idx=%0d err=%0d",
                     $time, a.busy, a.fp, a.bp, a.yl, a.we, a.dn, a.idx, a.err,
                     e.busy, e.fp, e.bp, e.yl, e.we, e.dn, e.idx, e.err);
         end
      end
   end

   task automatic check_zero(input string name);
      logic [37:0] act;
      act = {fp, bp, busy, y_latch, w_we, done, sample_idx, err_cnt};
      n_tests++;
      if (act !== 38'd0) begin
         n_fail++;
         $display("FAIL %s act=%h exp=0", name, act);
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         m_yh[i] = 32'h0001_0000;
         m_yt[i] = 32'h0001_0000;
      end
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset_state");
      rst_n = 1'b1;
      idle(3, 0, 0);

      run_pass(0, 3, -1, -1, 1000);          // inference, done at cycle 64
      idle(3, 0, 0);
      run_pass(1, 2, -1, 30, 1000);          // training, start while busy ignored
      idle(2, 0, 0);
      run_pass(0, 0, -1, -1, 1000);          // zero samples
      idle(3, 0, 0);
      run_pass(1, 4, 60, -1, 1000);          // abort in FWD of sample 1
      idle(3, 0, 0);
      idle(2, 1, 1);                         // abort+start in IDLE
      idle(2, 0, 0);
      run_pass(1, 1, 55, -1, 1000);          // abort in WB
      idle(3, 0, 0);

      m_yt[1] = 32'h0;
      m_yt[2] = 32'h0;
      run_pass(0, 4, -1, -1, 1000);
      idle(2, 0, 0);
      for (int i = 0; i < 8; i++) m_yt[i] = m_yh[i];
      run_pass(0, 2, -1, -1, 1000);
      idle(2, 0, 0);

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 8; i++) begin
            m_yh[i] = $urandom;
            m_yt[i] = ($urandom_range(0, 1) == 1) ? m_yh[i] : (m_yh[i] ^ (32'd1 << $urandom_range(0, 31)));
         end
         run_pass(1'($urandom_range(0, 1)), $urandom_range(1, 3),
                  ($urandom_range(0, 1) == 1) ? -2 : -1, $urandom_range(0, 100), 1000);
         idle($urandom_range(1, 4), 0, 0);
      end

      run_pass(1, 2, -1, -1, 90);            // stop mid-BWD of sample 1
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("async_reset_mid_bwd");
      m_idx = 0;
      m_err = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(5, 0, 0);

      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain act=%0d exp=0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
